lc3_mmio_responder: RTL
=======================

# lc3_mmio_responder

Memory-mapped I/O responder on the LC-3 memory bus. Sits between the LC-3 core (mar/mdr/memwe/memOut) and the data memory. It decodes the four LC-3 device-register addresses (KBSR, KBDR, DSR, DDR) and answers reads and writes to them. All other addresses pass through to RAM. The host side carries a buffered keyboard input stream and a handshaked display output stream.

## Interface
Parameters:
- KBD_DEPTH, 4: keyboard FIFO entries; power of two, ≥2.
- DISP_BUSY_CYCLES, 8: cycles DSR stays not-ready after the host accepts a character; ≥1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- mar  in  16  address from the core.
- mdr  in  16  write data from the core.
- memwe  in  1  write enable from the core; held high for one or more cycles per store.
- mem_rdata  in  16  read data from RAM (one-cycle registered read).
- mem_we  out  1  write enable to RAM; equals memwe & !io_hit.
- memOut  out  16  read data returned to the core.
- kbd_valid  in  1  host keyboard character valid.
- kbd_data  in  8  host keyboard character.
- kbd_ready  out  1  FIFO can accept a character.
- disp_valid  out  1  display character valid.
- disp_data  out  8  display character.
- disp_ready  in  1  host accepts the display character.

## Operation
- Decode: io_hit = mar ∈ {KBSR 0xFE00, KBDR 0xFE02, DSR 0xFE04, DDR 0xFE06}. Any other value, including 0xFE01/03/05/07, is a RAM access.
- Read data: io_rdata_q and io_sel_q are registered from mar each cycle. memOut = io_sel_q ? io_rdata_q : mem_rdata.
- KBSR read: bit15 = FIFO non-empty, bit14 = IE, all other bits 0.
- KBDR read: {8'h00, FIFO head}. If the FIFO is empty, the read returns 0x0000.
- DSR read: bit15 = display ready (FSM in D_IDLE), bit0 = sticky overflow, other bits 0.
- DDR read: {8'h00, last written character}.
- Store strobe: wr_stb = memwe & !memwe_q. Only one action is taken per store regardless of memwe hold length.
  - wr_stb to KBSR writes IE = mdr[14].
  - wr_stb to DSR with mdr[0]=1 clears overflow.
  - wr_stb to KBDR is ignored.
- Keyboard pop: on a read entry to KBDR, i.e. mar == KBDR & !memwe & mar_q != KBDR. Pop once; hold the popped value in io_rdata_q until mar leaves. A pop on an empty FIFO has no effect.
- Keyboard push: on kbd_valid & kbd_ready. kbd_ready = !full, from registered count.
  - Simultaneous push and pop, not full: count unchanged, order preserved.
  - At full: the pop is accepted and the push is refused that cycle.
- Display FSM:
  - D_IDLE: wr_stb to DDR latches mdr[7:0] into disp_data and moves to D_SEND.
  - D_SEND: disp_valid=1; disp_data is stable until disp_ready. disp_ready moves to D_BUSY with cnt = DISP_BUSY_CYCLES-1.
  - D_BUSY: cnt decrements; at cnt==0 move to D_IDLE.
  - wr_stb to DDR in D_SEND or D_BUSY: write dropped, overflow set to 1.

## Timing
- Reset values: FIFO empty, IE=0, overflow=0, FSM D_IDLE, disp_valid=0, disp_data=0, kbd_ready=1, io_sel_q=0, io_rdata_q=0, memwe_q=0, mar_q=0. memOut follows mem_rdata while io_sel_q=0.
- Read latency: one cycle from mar to memOut for I/O addresses, matching RAM.
- Status latency: KBSR[15] reflects a push in the cycle after the push edge.
- Display turnaround: D_IDLE → DDR write → D_SEND (1) → accept → D_BUSY for DISP_BUSY_CYCLES → DSR[15]=1.
- Reset mid-operation: an in-flight character is dropped, disp_valid falls asynchronously, and FIFO contents are lost.

## Structure
- lc3_mmio_pkg: device-register address constants, KBSR/DSR bit indices, display FSM state enum.
- Sub-module lc3_kbd_fifo: synchronous FIFO, parameter DEPTH, width 8, with push/pop/full/empty/count.
- The top holds the decode, the read register, the store strobe and the display FSM.

## Test plan
- Reset, then read 0xFE04 → memOut 0x8000 one cycle later. Read 0xFE00 → 0x0000.
- Host pushes 0x41, 0x42. Read KBSR → 0x8000. Read KBDR → 0x0041. Move mar away, read KBDR → 0x0042. KBSR → 0x0000.
- Push KBD_DEPTH+1 characters with no reads → kbd_ready low after KBD_DEPTH. Reads return the first KBD_DEPTH characters in order; the extra one is not stored.
- Store 0x0048 to 0xFE06 with memwe held 3 cycles → exactly one disp_valid transfer of 0x48, mem_we stays 0. With disp_ready held low 5 cycles, disp_data stays stable.
- Second DDR store during D_BUSY → no new transfer, DSR reads 0x0001. Store 0x0001 to DSR and wait out DISP_BUSY_CYCLES → DSR reads 0x8000.
- Store 0x1234 to 0x3000 → mem_we=1. Reading 0x3000 returns mem_rdata. Assert reset during D_SEND → disp_valid=0 immediately, DSR=0x8000 after release.

Source files
------------

// File: rtl/lc3_mmio_pkg.sv
// Shared definitions for the LC-3 memory-mapped I/O responder:
// device register addresses, status bit positions and display FSM states.
package lc3_mmio_pkg;

  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;

  localparam int KBSR_RDY_BIT = 15;
  localparam int KBSR_IE_BIT  = 14;
  localparam int DSR_RDY_BIT  = 15;
  localparam int DSR_OVF_BIT  = 0;

  localparam logic [1:0] D_IDLE = 2'd0;
  localparam logic [1:0] D_SEND = 2'd1;
  localparam logic [1:0] D_BUSY = 2'd2;

  function automatic logic is_io_addr(input logic [15:0] addr);
    return (addr == KBSR_ADDR) || (addr == KBDR_ADDR) ||
           (addr == DSR_ADDR)  || (addr == DDR_ADDR);
  endfunction

endpackage

// File: rtl/lc3_kbd_fifo.sv
// Keyboard character FIFO, 8 bits wide, DEPTH entries (power of two).
// Push is refused while full; pop on empty is ignored.
module lc3_kbd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [7:0]               i_push_dat,
  input  logic                     i_pop,
  output logic [7:0]               o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;

  // Storage is not reset: clearing the pointers is enough to discard contents.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/lc3_mmio_responder.sv
// LC-3 MMIO responder: decodes KBSR/KBDR/DSR/DDR, answers them with the same
// one-cycle read latency as RAM, and passes every other address through to RAM.
module lc3_mmio_responder
  import lc3_mmio_pkg::*;
#(
  parameter int KBD_DEPTH        = 4,
  parameter int DISP_BUSY_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] mar,
  input  logic [15:0] mdr,
  input  logic        memwe,
  input  logic [15:0] mem_rdata,
  output logic        mem_we,
  output logic [15:0] memOut,
  input  logic        kbd_valid,
  input  logic [7:0]  kbd_data,
  output logic        kbd_ready,
  output logic        disp_valid,
  output logic [7:0]  disp_data,
  input  logic        disp_ready
);

  localparam int CW = $clog2(DISP_BUSY_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(DISP_BUSY_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic        r_memwe_q;
  logic [15:0] r_mar_q;
  logic        r_io_sel;
  logic [15:0] r_io_rdata;
  logic        r_ie;
  logic        r_ovf;
  logic [1:0]  r_state;
  logic [CW-1:0] r_cnt;
  logic [7:0]  r_disp_data;

  logic        w_io_hit;
  logic        w_wr_stb;
  logic        w_kbdr_entry;
  logic        w_pop;
  logic [7:0]  w_head;
  logic        w_full;
  logic        w_empty;
  logic [$clog2(KBD_DEPTH):0] w_count;
  logic [15:0] w_rd_next;
  logic        w_unused_mdr;

  assign w_io_hit     = is_io_addr(mar);
  assign w_wr_stb     = memwe & ~r_memwe_q;
  assign w_kbdr_entry = (mar == KBDR_ADDR) & (r_mar_q != KBDR_ADDR);
  assign w_pop        = w_kbdr_entry & ~memwe;
  assign w_unused_mdr = &{1'b0, mdr[15], mdr[13:8]};

  assign mem_we     = memwe & ~w_io_hit;
  assign memOut     = r_io_sel ? r_io_rdata : mem_rdata;
  assign kbd_ready  = ~w_full;
  assign disp_valid = (r_state == D_SEND);
  assign disp_data  = r_disp_data;

  lc3_kbd_fifo #(.DEPTH(KBD_DEPTH)) u_kbd_fifo (
    .clk        (clk),
    .rst_n      (reset),
    .i_push     (kbd_valid),
    .i_push_dat (kbd_data),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (w_count)
  );

  // KBDR captures the head once on entry and then holds it until mar moves away.
  always_comb begin
    w_rd_next = 16'h0000;
    case (mar)
      KBSR_ADDR: begin
        w_rd_next[KBSR_RDY_BIT] = (w_count != '0);
        w_rd_next[KBSR_IE_BIT]  = r_ie;
      end
      KBDR_ADDR: begin
        if (w_kbdr_entry) w_rd_next = w_empty ? 16'h0000 : {8'h00, w_head};
        else              w_rd_next = r_io_rdata;
      end
      DSR_ADDR: begin
        w_rd_next[DSR_RDY_BIT] = (r_state == D_IDLE);
        w_rd_next[DSR_OVF_BIT] = r_ovf;
      end
      DDR_ADDR: w_rd_next = {8'h00, r_disp_data};
      default:  w_rd_next = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_memwe_q  <= 1'b0;
      r_mar_q    <= 16'h0000;
      r_io_sel   <= 1'b0;
      r_io_rdata <= 16'h0000;
      r_ie       <= 1'b0;
    end else begin
      r_memwe_q  <= memwe;
      r_mar_q    <= mar;
      r_io_sel   <= w_io_hit;
      r_io_rdata <= w_rd_next;
      if (w_wr_stb && mar == KBSR_ADDR) r_ie <= mdr[KBSR_IE_BIT];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= D_IDLE;
      r_cnt       <= '0;
      r_disp_data <= 8'h00;
      r_ovf       <= 1'b0;
    end else begin
      if (w_wr_stb && mar == DDR_ADDR && r_state != D_IDLE)
        r_ovf <= 1'b1;
      else if (w_wr_stb && mar == DSR_ADDR && mdr[DSR_OVF_BIT])
        r_ovf <= 1'b0;

      case (r_state)
        D_IDLE: begin
          if (w_wr_stb && mar == DDR_ADDR) begin
            r_disp_data <= mdr[7:0];
            r_state     <= D_SEND;
          end
        end
        D_SEND: begin
          if (disp_ready) begin
            r_state <= D_BUSY;
            r_cnt   <= CNT_INIT;
          end
        end
        D_BUSY: begin
          if (r_cnt == '0) r_state <= D_IDLE;
          else             r_cnt   <= r_cnt - CNT_ONE;
        end
        default: r_state <= D_IDLE;
      endcase
    end
  end

endmodule
